// File: rtl/bank_sel_arbiter.sv
// bank_sel_arbiter: round-robin arbiter that hands the shared two-bank
// select/mode datapath to one of NREQ requesters for a programmed burst,
// then holds a settle gap before the next grant.
// Optional feature macro: ARB_LOCK_EN (adds the per-requester lock input).
module bank_sel_arbiter #(
    parameter int NREQ   = 4,
    parameter int MODE_W = 3,
    parameter int LEN_W  = 4,
    parameter int SETTLE = 2,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          bank_in,
    input  logic [NREQ*MODE_W-1:0]   mode_in,
    input  logic [NREQ*LEN_W-1:0]    len_in,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     dp_sel,
    output logic [MODE_W-1:0]        dp_mode,
    output logic                     dp_valid,
    output logic                     done,
    output logic [ID_W-1:0]          done_id
`ifdef ARB_LOCK_EN
    ,
    input  logic [NREQ-1:0]          lock
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE
    } state_t;

    localparam logic [2:0]      SETTLE_CNT = 3'(SETTLE);
    localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NREQ - 1);

    state_t            state, state_d;
    logic [ID_W-1:0]   ptr;        // round-robin start point
    logic [ID_W-1:0]   cur_id;     // owner of the current / last burst
    logic [LEN_W-1:0]  cnt;        // beats left in the burst
    logic [2:0]        scnt;       // settle cycles left
    logic              lock_hold;  // regrant cur_id at the next arbitration
    logic              lock_take;

    logic [ID_W-1:0]   win_id;
    logic [NREQ-1:0]   gnt_d;
    logic              win_bank;
    logic [MODE_W-1:0] win_mode;
    logic [LEN_W-1:0]  win_len;
    logic              arb_point;
    logic              grant_now;
    logic              burst_end;

`ifdef ARB_LOCK_EN
    assign lock_take = lock[cur_id] && req[cur_id];
`else
    assign lock_take = 1'b0;
`endif

    assign arb_point = (state == ST_IDLE) || ((state == ST_SETTLE) && (scnt == 3'd0));
    assign grant_now = arb_point && (|req);
    assign burst_end = (state == ST_RUN) && (cnt == LEN_W'(1));
    assign busy      = (state != ST_IDLE);

    // Winner: first asserted req scanning from ptr with wrap; a held lock overrides.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        idx    = 0;
        sel    = '0;
        win_id = '0;
        // Descending scan: the last hit written is the nearest one after ptr.
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = ID_W'(idx);
            if (req[sel]) win_id = sel;
        end
        if (lock_hold && req[cur_id]) win_id = cur_id;
    end

    // Mux the winner's sideband fields and build its one-hot grant.
    always_comb begin
        gnt_d    = '0;
        win_bank = 1'b0;
        win_mode = '0;
        win_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == win_id) begin
                gnt_d[i] = 1'b1;
                win_bank = bank_in[i];
                win_mode = mode_in[i*MODE_W +: MODE_W];
                win_len  = len_in[i*LEN_W +: LEN_W];
            end
        end
    end

    // Next-state logic for the IDLE / RUN / SETTLE sequencer.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (grant_now) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (burst_end) state_d = (SETTLE == 0) ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (scnt == 3'd0) state_d = grant_now ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // Grant, datapath drive, burst/settle counters and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            dp_sel    <= 1'b0;
            dp_mode   <= '0;
            dp_valid  <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
            ptr       <= '0;
            cur_id    <= '0;
            cnt       <= '0;
            scnt      <= '0;
            lock_hold <= 1'b0;
        end else begin
            done <= 1'b0;
            if (grant_now) begin
                // Sideband inputs are captured here only; later changes are ignored.
                gnt       <= gnt_d;
                dp_sel    <= win_bank;
                dp_mode   <= win_mode;
                dp_valid  <= 1'b1;
                cur_id    <= win_id;
                cnt       <= (win_len == '0) ? LEN_W'(1) : win_len;
                lock_hold <= 1'b0;
            end else if (burst_end) begin
                gnt       <= '0;
                dp_valid  <= 1'b0;
                done      <= 1'b1;
                done_id   <= cur_id;
                cnt       <= '0;
                scnt      <= SETTLE_CNT;
                lock_hold <= lock_take;
                // A locked requester keeps the round-robin pointer where it is.
                if (!lock_take) ptr <= (cur_id == LAST_ID) ? '0 : cur_id + ID_W'(1);
            end else begin
                if (state == ST_RUN) cnt <= cnt - LEN_W'(1);
                if ((state == ST_SETTLE) && (scnt != 3'd0)) scnt <= scnt - 3'd1;
                // Arbitration point with nobody requesting drops any held lock.
                if (arb_point) lock_hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bank_sel_arbiter.sv
// Directed self-checking bench for bank_sel_arbiter (NREQ=4, MODE_W=3,
// LEN_W=4, SETTLE=2). Inputs change and outputs are sampled on the falling edge.
module tb_bank_sel_arbiter;

    localparam int NREQ   = 4;
    localparam int MODE_W = 3;
    localparam int LEN_W  = 4;
    localparam int SETTLE = 2;
    localparam int ID_W   = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        bank_in;
    logic [NREQ*MODE_W-1:0] mode_in;
    logic [NREQ*LEN_W-1:0]  len_in;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   dp_sel;
    logic [MODE_W-1:0]      dp_mode;
    logic                   dp_valid;
    logic                   done;
    logic [ID_W-1:0]        done_id;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]        lock;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    bank_sel_arbiter #(
        .NREQ(NREQ), .MODE_W(MODE_W), .LEN_W(LEN_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bank_in(bank_in),
        .mode_in(mode_in), .len_in(len_in), .gnt(gnt), .busy(busy),
        .dp_sel(dp_sel), .dp_mode(dp_mode), .dp_valid(dp_valid),
        .done(done), .done_id(done_id)
`ifdef ARB_LOCK_EN
        , .lock(lock)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply reset with quiet inputs, verify reset outputs, release on a falling edge.
    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        req     = '0;
        bank_in = '0;
        mode_in = '0;
        len_in  = '0;
`ifdef ARB_LOCK_EN
        lock    = '0;
`endif
        repeat (2) @(negedge clk);
        check({tag, " rst gnt"},     gnt,      32'h0);
        check({tag, " rst busy"},    busy,     32'h0);
        check({tag, " rst dp_sel"},  dp_sel,   32'h0);
        check({tag, " rst dp_mode"}, dp_mode,  32'h0);
        check({tag, " rst valid"},   dp_valid, 32'h0);
        check({tag, " rst done"},    done,     32'h0);
        check({tag, " rst done_id"}, done_id,  32'h0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // ---- Test 1: reset pulse during beat 2 of a len=5 burst ----
        do_reset("t1");
        req = 4'b0001; bank_in = 4'b0001; mode_in[2:0] = 3'd7; len_in[3:0] = 4'd5;
        @(negedge clk);
        check("t1 gnt beat1", gnt, 32'h1);
        check("t1 mode beat1", dp_mode, 32'd7);
        check("t1 sel beat1", dp_sel, 32'h1);
        @(negedge clk);
        check("t1 valid beat2", dp_valid, 32'h1);
        #1 rst_n = 1'b0; req = '0;
        #1;
        check("t1 async gnt", gnt, 32'h0);
        check("t1 async busy", busy, 32'h0);
        check("t1 async valid", dp_valid, 32'h0);
        check("t1 async sel", dp_sel, 32'h0);
        check("t1 async mode", dp_mode, 32'h0);
        check("t1 async done", done, 32'h0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t1 post done", done, 32'h0);
            check("t1 post busy", busy, 32'h0);
            check("t1 post gnt", gnt, 32'h0);
        end

        // ---- Test 2: single len=3 burst from requester 2 ----
        do_reset("t2");
        req = 4'b0100; bank_in = 4'b0100; mode_in[8:6] = 3'd5; len_in[11:8] = 4'd3;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("t2 gnt", gnt, (c <= 3) ? 32'h4 : 32'h0);
            check("t2 valid", dp_valid, (c <= 3) ? 32'h1 : 32'h0);
            check("t2 done", done, (c == 4) ? 32'h1 : 32'h0);
            check("t2 busy", busy, (c <= 6) ? 32'h1 : 32'h0);
            if (c <= 4) begin
                check("t2 dp_sel", dp_sel, 32'h1);
                check("t2 dp_mode", dp_mode, 32'd5);
            end
            if (c == 4) check("t2 done_id", done_id, 32'd2);
            if (c == 1) req = '0;
        end

        // ---- Test 3: all requesting, len=1, order 0,1,2,3,0 spaced by 4 ----
        do_reset("t3");
        req = 4'b1111; len_in = 16'h1111;
        mode_in = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            check("t3 gnt", gnt, (c % 4 == 1) ? (32'h1 << ((c / 4) % 4)) : 32'h0);
            check("t3 valid", dp_valid, (c % 4 == 1) ? 32'h1 : 32'h0);
            if (c % 4 == 1) check("t3 dp_mode", dp_mode, 32'(((c / 4) % 4) + 1));
        end
        req = '0;

        // ---- Test 4: len 0 is one beat ----
        do_reset("t4");
        req = 4'b0010; len_in = 16'h0000;
        @(negedge clk);
        check("t4 gnt", gnt, 32'h2);
        check("t4 valid beat", dp_valid, 32'h1);
        req = '0;
        @(negedge clk);
        check("t4 valid after", dp_valid, 32'h0);
        check("t4 done", done, 32'h1);
        check("t4 done_id", done_id, 32'd1);
        @(negedge clk);
        check("t4 valid settle", dp_valid, 32'h0);

        // ---- Test 5: req=1001, len=2, alternating 0,3 with wrap; mode held ----
        do_reset("t5");
        req = 4'b1001; len_in = 16'h2222;
        mode_in = {3'd6, 3'd0, 3'd0, 3'd3};
        for (int c = 1; c <= 17; c++) begin
            int k, g;
            k = (c - 1) % 5;
            g = (c - 1) / 5;
            @(negedge clk);
            check("t5 gnt", gnt, (k < 2) ? ((g % 2 == 1) ? 32'h8 : 32'h1) : 32'h0);
            check("t5 dp_mode", dp_mode, (g % 2 == 1) ? 32'd6 : 32'd3);
            check("t5 done", done, (k == 2) ? 32'h1 : 32'h0);
            if (k == 2) check("t5 done_id", done_id, (g % 2 == 1) ? 32'd3 : 32'd0);
        end
        req = '0;

`ifdef ARB_LOCK_EN
        // ---- Lock: requester 0 regranted 3 times, then lock drop hands over to 1 ----
        do_reset("tl");
        req = 4'b0011; len_in = 16'h1111; lock = 4'b0001;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            check("tl gnt", gnt, (c == 17) ? 32'h2 : ((c % 4 == 1) ? 32'h1 : 32'h0));
            check("tl done", done, (c % 4 == 2) ? 32'h1 : 32'h0);
            if (c == 13) lock = '0;
        end
        req = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
